// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed 7-segment scan bus: debounces each dwell,
// decodes segments to BCD and tracks in-order frames. Optional stall timer: `SCAN_TIMEOUT_EN.
module seg_scan_decoder #(
    parameter int STABLE_CNT  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       display_clk,
    input  logic       i_rst,
    input  logic [7:0] i_seg,
    input  logic [3:0] i_dig_sel,
    output logic [3:0] o_dig1,
    output logic [3:0] o_dig2,
    output logic [3:0] o_dig3,
    output logic [3:0] o_dig4,
    output logic [3:0] o_dp,
    output logic       o_frame_valid,
    output logic       o_seg_err,
    output logic       o_sel_err,
    output logic       o_order_err,
    output logic [7:0] o_frame_cnt,
    output logic       o_stalled
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    typedef enum logic [1:0] {HUNT, EXP2, EXP3, EXP4} state_t;

    // Returns {error, value}; blank maps to F, unknown patterns to E.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_seg = 5'h00;
            7'h06:   decode_seg = 5'h01;
            7'h5B:   decode_seg = 5'h02;
            7'h4F:   decode_seg = 5'h03;
            7'h66:   decode_seg = 5'h04;
            7'h6D:   decode_seg = 5'h05;
            7'h7D:   decode_seg = 5'h06;
            7'h07:   decode_seg = 5'h07;
            7'h7F:   decode_seg = 5'h08;
            7'h6F:   decode_seg = 5'h09;
            7'h00:   decode_seg = 5'h0F;
            default: decode_seg = 5'h1E;
        endcase
    endfunction

    // Returns {legal, digit index}.
    function automatic logic [2:0] decode_sel(input logic [3:0] sel);
        case (sel)
            4'b1110: decode_sel = 3'b100;
            4'b1101: decode_sel = 3'b101;
            4'b1011: decode_sel = 3'b110;
            4'b0111: decode_sel = 3'b111;
            default: decode_sel = 3'b000;
        endcase
    endfunction

    logic [7:0]       r_seg_p0, r_seg_p1;
    logic [3:0]       r_sel_p0, r_sel_p1;
    logic [CNT_W-1:0] r_cnt_p1;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_same;
    logic             w_cap_vld;
    logic [4:0]       w_dec;
    logic [2:0]       w_sel;
    logic [1:0]       w_idx;
    logic             w_legal;
    logic             w_illegal;

    state_t     r_state;
    logic       r_frm_err;
    logic [3:0] r_dig [4];
    logic [3:0] r_dp;
    logic       r_frame_valid, r_seg_err, r_sel_err, r_order_err;
    logic [7:0] r_frame_cnt;

    // Stage p0: raw sample; stage p1: previous sample for dwell comparison
    always_ff @(posedge display_clk) begin
        r_seg_p0 <= i_seg;
        r_sel_p0 <= i_dig_sel;
        r_seg_p1 <= r_seg_p0;
        r_sel_p1 <= r_sel_p0;
    end

    assign w_same = (r_seg_p0 == r_seg_p1) && (r_sel_p0 == r_sel_p1);

    always_comb begin
        w_cnt_nxt = CNT_W'(1);
        if (w_same)
            w_cnt_nxt = (r_cnt_p1 == CNT_MAX) ? CNT_MAX : r_cnt_p1 + 1'b1;
    end

    // Fire only on the transition into saturation so each dwell captures once
    assign w_cap_vld = (w_cnt_nxt == CNT_MAX) && !(w_same && (r_cnt_p1 == CNT_MAX));

    always_ff @(posedge display_clk) begin
        if (i_rst)
            r_cnt_p1 <= '0;
        else
            r_cnt_p1 <= w_cnt_nxt;
    end

    assign w_dec     = decode_seg(r_seg_p0[6:0]);
    assign w_sel     = decode_sel(r_sel_p0);
    assign w_idx     = w_sel[1:0];
    assign w_legal   = w_cap_vld && w_sel[2];
    assign w_illegal = w_cap_vld && !w_sel[2] && (r_sel_p0 != 4'hF);

    // Stage p2: capture, frame sequencing and registered outputs
    always_ff @(posedge display_clk) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_frm_err     <= 1'b0;
            r_dig         <= '{4'hF, 4'hF, 4'hF, 4'hF};
            r_dp          <= 4'h0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_sel_err     <= 1'b0;
            r_order_err   <= 1'b0;
            r_frame_cnt   <= 8'h00;
        end else begin
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_sel_err     <= 1'b0;
            r_order_err   <= 1'b0;
            if (w_illegal) begin
                r_sel_err <= 1'b1;
                r_state   <= HUNT;
            end else if (w_legal) begin
                r_dig[w_idx] <= w_dec[3:0];
                r_dp[w_idx]  <= r_seg_p0[7];
                r_seg_err    <= w_dec[4];
                if (r_state == HUNT) begin
                    if (w_idx == 2'd0) begin
                        r_state   <= EXP2;
                        r_frm_err <= w_dec[4];
                    end else begin
                        r_frm_err <= r_frm_err | w_dec[4];
                    end
                end else if (r_state == state_t'(w_idx)) begin
                    if (r_state == EXP4) begin
                        r_state <= HUNT;
                        if (!r_frm_err && !w_dec[4]) begin
                            r_frame_valid <= 1'b1;
                            r_frame_cnt   <= r_frame_cnt + 8'd1;
                        end
                    end else begin
                        r_state   <= state_t'(w_idx + 2'd1);
                        r_frm_err <= r_frm_err | w_dec[4];
                    end
                end else begin
                    r_order_err <= 1'b1;
                    if (w_idx == 2'd0) begin
                        r_state   <= EXP2;
                        r_frm_err <= w_dec[4];
                    end else begin
                        r_state   <= HUNT;
                        r_frm_err <= r_frm_err | w_dec[4];
                    end
                end
            end
        end
    end

    assign o_dig1        = r_dig[0];
    assign o_dig2        = r_dig[1];
    assign o_dig3        = r_dig[2];
    assign o_dig4        = r_dig[3];
    assign o_dp          = r_dp;
    assign o_frame_valid = r_frame_valid;
    assign o_seg_err     = r_seg_err;
    assign o_sel_err     = r_sel_err;
    assign o_order_err   = r_order_err;
    assign o_frame_cnt   = r_frame_cnt;

`ifdef SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge display_clk) begin
        if (i_rst || w_legal)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign o_stalled = (r_to_cnt == TO_MAX);
`else
    assign o_stalled = 1'b0;
`endif

endmodule
